// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the button debouncer
package debounce_pkg;

    localparam int DEFAULT_SETTLE_50MHZ = 500000;
    localparam int DEFAULT_HOLD_50MHZ = 50000000;

    // Bits needed to hold values 0..value-1, never less than one
    function automatic int clog2(input longint value);
        int r;
        r = 0;
        while ((longint'(1) << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel - synchroniser, settle filter, edge pulses, long-press pulse
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_50MHZ,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_50MHZ,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk_50_mhz,
    input  logic reset_n,
    input  logic button_raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic held
);

    localparam int CW = clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    logic sync1, sync2, cand, sample, settle_done;
    logic [CW-1:0] cnt;

    assign sample = sync2 ^ RAW_IDLE;
    assign settle_done = (cnt == SETTLE_MAX) && (cand != level);

    always_ff @(posedge clk_50_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
            cand <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
            pressed <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
            cand <= sample;
            cnt <= (sample != cand) ? '0 : (cnt == SETTLE_MAX) ? cnt : cnt + 1'b1;
            level <= settle_done ? cand : level;
            pressed <= settle_done && cand;
            released <= settle_done && !cand;
        end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int HW = clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
        logic [HW-1:0] hcnt;
        // A release landing on the same edge wins, keeping the three pulses exclusive
        always_ff @(posedge clk_50_mhz or negedge reset_n) begin
            if (!reset_n) begin
                hcnt <= '0;
                held <= 1'b0;
            end else begin
                hcnt <= !level ? '0 : (hcnt == HOLD_MAX) ? hcnt : hcnt + 1'b1;
                held <= level && (hcnt == HOLD_MAX - 1'b1) && !settle_done;
            end
        end
    end else begin : g_no_hold
        assign held = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: independent debounce channels for a bank of raw push-button pins
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_50MHZ,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_50MHZ,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk_50_mhz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk_50_mhz(clk_50_mhz),
            .reset_n(reset_n),
            .button_raw(button_raw[i]),
            .level(level[i]),
            .pressed(pressed[i]),
            .released(released[i]),
            .held(held[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table, directed and random checks of two debounce_bank configurations
module tb_debounce_bank;

    localparam int CHANNELS = 3;
    localparam int S = 4;
    localparam int H = 10;
    localparam int D = S + 4;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] lev;
        logic [2:0] pr;
        logic [2:0] rl;
        logic [2:0] hd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [2:0] raw_a, raw_b;
    logic [2:0] lev_a, pr_a, rl_a, hd_a;
    logic [2:0] lev_b, pr_b, rl_b, hd_b;

    int vectors = 0;
    int misc = 0;

    // Model state: instance 0 is active-low with hold, instance 1 active-high without
    logic hist [2][CHANNELS][D];
    logic mlev [2][CHANNELS];
    int age [2][CHANNELS];
    logic [2:0] e_lev [2];
    logic [2:0] e_pr [2];
    logic [2:0] e_rl [2];
    logic [2:0] e_hd [2];

    vec_t tbl [20];

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(CHANNELS), .SETTLE_CYCLES(S), .HOLD_CYCLES(H), .ACTIVE_LOW(1)
    ) dut_a (
        .clk_50_mhz(clk), .reset_n(reset_n), .button_raw(raw_a),
        .level(lev_a), .pressed(pr_a), .released(rl_a), .held(hd_a)
    );

    debounce_bank #(
        .CHANNELS(CHANNELS), .SETTLE_CYCLES(S), .HOLD_CYCLES(0), .ACTIVE_LOW(0)
    ) dut_b (
        .clk_50_mhz(clk), .reset_n(reset_n), .button_raw(raw_b),
        .level(lev_b), .pressed(pr_b), .released(rl_b), .held(hd_b)
    );

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            misc++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int d = 0; d < D; d++) hist[n][c][d] = 1'b0;
                mlev[n][c] = 1'b0;
                age[n][c] = 0;
            end
            e_lev[n] = '0;
            e_pr[n] = '0;
            e_rl[n] = '0;
            e_hd[n] = '0;
        end
    endtask

    // Level follows the pressed state once it has been seen on S+1 consecutive
    // edges, three edges of pipeline after capture; held fires H edges after a rise.
    task automatic model_edge(input logic [2:0] ra, input logic [2:0] rb);
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                logic v, nl, stable, prev;
                int hold;
                hold = (n == 0) ? H : 0;
                for (int d = D - 1; d > 0; d--) hist[n][c][d] = hist[n][c][d-1];
                hist[n][c][0] = (n == 0) ? !ra[c] : rb[c];
                v = hist[n][c][3];
                stable = 1'b1;
                for (int d = 3; d <= 3 + S; d++) if (hist[n][c][d] != v) stable = 1'b0;
                prev = mlev[n][c];
                nl = stable ? v : prev;
                age[n][c] = (prev && nl) ? age[n][c] + 1 : 0;
                e_pr[n][c] = !prev && nl;
                e_rl[n][c] = prev && !nl;
                e_hd[n][c] = (hold > 0) && prev && nl && (age[n][c] == hold);
                e_lev[n][c] = nl;
                mlev[n][c] = nl;
            end
        end
    endtask

    task automatic step(input logic [2:0] ra, input logic [2:0] rb);
        raw_a = ra;
        raw_b = rb;
        @(posedge clk);
        if (reset_n) model_edge(ra, rb);
        else model_reset();
        @(negedge clk);
        check("model_a", {lev_a, pr_a, rl_a, hd_a}, {e_lev[0], e_pr[0], e_rl[0], e_hd[0]});
        check("model_b", {lev_b, pr_b, rl_b, hd_b}, {e_lev[1], e_pr[1], e_rl[1], e_hd[1]});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got no summary, expected one");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] acc, acc_b, ra, rb, flip;
        int pc, pi, hc, hi, ri;

        for (int j = 0; j < 20; j++) begin
            tbl[j].raw = 3'b110;
            tbl[j].lev = (j >= 7) ? 3'b001 : 3'b000;
            tbl[j].pr = (j == 7) ? 3'b001 : 3'b000;
            tbl[j].rl = 3'b000;
            tbl[j].hd = (j == 17) ? 3'b001 : 3'b000;
        end

        reset_n = 1'b0;
        raw_a = 3'b111;
        raw_b = 3'b000;
        model_reset();
        repeat (3) step(3'b111, 3'b000);
        check("reset_outputs", {lev_a, pr_a, rl_a, hd_a}, 12'h000);
        reset_n = 1'b1;

        acc = '0;
        for (int j = 0; j < 20; j++) begin
            step(3'b111, 3'b000);
            acc |= pr_a | rl_a | hd_a | lev_a;
        end
        check("quiet_after_reset", 12'(acc), 12'h000);

        for (int j = 0; j < 20; j++) begin
            step(tbl[j].raw, 3'b000);
            check("tbl_level", 12'(lev_a), 12'(tbl[j].lev));
            check("tbl_pulses", {3'b000, pr_a, rl_a, hd_a}, {3'b000, tbl[j].pr, tbl[j].rl, tbl[j].hd});
        end

        for (int j = 0; j < 12; j++) begin
            step(3'b111, 3'b000);
            if (j == 7) check("release_ch0", 12'(rl_a), 12'h001);
        end

        acc = '0;
        for (int j = 0; j < 40; j++) begin
            step((((j / 2) % 2) == 0 && j < 30) ? 3'b101 : 3'b111, 3'b000);
            acc[1] |= lev_a[1] | pr_a[1] | rl_a[1];
        end
        check("bounce_reject", 12'(acc), 12'h000);

        acc = '0;
        for (int j = 0; j < 14; j++) begin
            step((j < 4) ? 3'b101 : 3'b111, 3'b000);
            acc[1] |= lev_a[1] | pr_a[1] | rl_a[1];
        end
        check("glitch4_reject", 12'(acc), 12'h000);

        pc = 0; pi = -1; ri = -1;
        for (int j = 0; j < 17; j++) begin
            step((j < 5) ? 3'b101 : 3'b111, 3'b000);
            if (pr_a[1]) begin pc++; pi = j; end
            if (rl_a[1]) ri = j;
        end
        check("glitch5_press_at", 12'(pi), 12'd7);
        check("glitch5_press_count", 12'(pc), 12'd1);
        check("glitch5_release_at", 12'(ri), 12'd12);

        pc = 0; pi = -1; hc = 0; hi = -1; ri = -1;
        for (int j = 0; j < 52; j++) begin
            step((j < 40) ? 3'b011 : 3'b111, 3'b000);
            if (pr_a[2]) begin pc++; pi = j; end
            if (hd_a[2]) begin hc++; hi = j; end
            if (rl_a[2]) ri = j;
        end
        check("long_press_at", 12'(pi), 12'd7);
        check("long_press_count", 12'(pc), 12'd1);
        check("long_held_at", 12'(hi), 12'd17);
        check("long_held_count", 12'(hc), 12'd1);
        check("long_release_at", 12'(ri), 12'd47);

        for (int j = 0; j < 12; j++) begin
            step(3'b010, 3'b000);
            if (j == 7) check("simul_press", 12'(pr_a), 12'h005);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_a", {lev_a, pr_a, rl_a, hd_a}, 12'h000);
        check("async_reset_b", {lev_b, pr_b, rl_b, hd_b}, 12'h000);
        model_reset();
        repeat (2) step(3'b010, 3'b000);
        reset_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step(3'b010, 3'b000);
            if (j == 6) check("post_reset_level_early", 12'(lev_a), 12'h000);
            if (j == 7) check("post_reset_press", 12'(pr_a), 12'h005);
        end
        repeat (12) step(3'b111, 3'b000);

        ra = 3'b111;
        rb = 3'b000;
        for (int k = 0; k < 800; k++) begin
            flip = '0;
            for (int c = 0; c < CHANNELS; c++)
                if ($urandom_range(0, (k % 200 < 100) ? 3 : 15) == 0) flip[c] = 1'b1;
            ra ^= flip;
            flip = '0;
            for (int c = 0; c < CHANNELS; c++)
                if ($urandom_range(0, (k % 200 < 100) ? 15 : 3) == 0) flip[c] = 1'b1;
            rb ^= flip;
            step(ra, rb);
        end

        repeat (15) step(3'b111, 3'b000);
        acc_b = '0;
        for (int j = 0; j < 100; j++) begin
            step(3'b111, 3'b001);
            if (j == 6) check("polarity_level_early", 12'(lev_b), 12'h000);
            if (j == 7) check("polarity_level", 12'(lev_b), 12'h001);
            acc_b |= hd_b;
        end
        check("hold_disabled", 12'(acc_b), 12'h000);
        repeat (10) step(3'b111, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner sitting between the board's raw button pins and the traffic-light control logic. Each channel synchronises its raw input, normalises polarity, and debounces against a settle counter. It emits:
- a clean level,
- one-cycle press and release pulses,
- an optional one-cycle long-press pulse.

All channels share one clock and reset and operate independently.

## Interface
- CHANNELS, 4, number of independent button channels (≥1)
- SETTLE_CYCLES, 500000, cycles the synchronised input must hold steady before the level changes (10 ms at 50 MHz; ≥1)
- HOLD_CYCLES, 50000000, cycles of continuous pressed level before `held` pulses (1 s at 50 MHz); 0 disables long-press detection
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed
- clk_50_mhz  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- button_raw  input  CHANNELS  raw asynchronous button pins, bit i = channel i
- level  output  CHANNELS  debounced state, 1 = pressed (polarity already normalised)
- pressed  output  CHANNELS  one-cycle pulse on a level 0→1 transition
- released  output  CHANNELS  one-cycle pulse on a level 1→0 transition
- held  output  CHANNELS  one-cycle pulse when level has been 1 for HOLD_CYCLES cycles

## Operation
The following applies per channel i.

**Synchroniser**
- Two flops, sync1 then sync2.
- Reset value is the raw *released* level: ACTIVE_LOW ? 1 : 0.
- Normalised sample: s = sync2 ^ ACTIVE_LOW.

**Settle logic**
- Register cand, reset 0.
- Counter cnt, width $clog2(SETTLE_CYCLES+1), reset 0.
- If s != cand: cand <= s and cnt <= 0.
- Else if cnt < SETTLE_CYCLES: cnt <= cnt+1. The counter saturates at SETTLE_CYCLES and never wraps.
- When cnt == SETTLE_CYCLES and cand != level: level <= cand.
  - Assert `pressed` (cand=1) or `released` (cand=0) for exactly that cycle.

**Glitches**
- A glitch on s lasting fewer than SETTLE_CYCLES+1 cycles never changes level.
- A glitch only restarts the count.

**Hold logic (HOLD_CYCLES > 0)**
- Counter hcnt, width $clog2(HOLD_CYCLES+1), reset 0.
- Cleared whenever level == 0.
- Increments while level == 1, saturating at HOLD_CYCLES.
- `held` pulses for one cycle on the cycle hcnt transitions to HOLD_CYCLES.
  - Exactly one pulse per press, however long the press lasts.
- When HOLD_CYCLES == 0, `held` is tied to 0 and no hold counter is generated.

**Other rules**
- Channels share no state. Simultaneous events on different channels are handled independently and in the same cycle.
- Reset values: level, pressed, released, held, cand, cnt and hcnt are all 0; sync flops hold the released raw level.
- reset_n asserted mid-operation clears everything immediately (asynchronously). No pulses are emitted on reset entry or exit.
- A button already held through reset release produces a normal `pressed` pulse after the settle time.

## Timing
- Raw change captured into sync1 at edge E0. Then:
  - sync2 at E0+1
  - cand and cnt=0 at E0+2
  - cnt reaches SETTLE_CYCLES at E0+2+SETTLE_CYCLES
  - level, pressed and released update at E0+3+SETTLE_CYCLES
- Total raw-to-level latency: SETTLE_CYCLES+3 edges after first capture.
- held asserts HOLD_CYCLES edges after level rises.
- pressed, released and held are registered, high for exactly one cycle, and mutually exclusive per channel per cycle.
- No handshake: pulses are fire-and-forget. Consumers sample every cycle.

## Structure
- Shared package debounce_pkg holds:
  - DEFAULT_SETTLE_50MHZ = 500000
  - DEFAULT_HOLD_50MHZ = 50000000
  - a clog2 helper function used for counter widths.
- One sub-module, debounce_chan, implements a single channel: synchroniser, settle, level, edge pulses and hold.
- debounce_bank instantiates debounce_chan CHANNELS times in a generate loop.
- No logic at the top level beyond bit slicing.

## Test plan
Bench parameters: CHANNELS=3, SETTLE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1.
- **Reset:** reset_n=0 with button_raw=3'b111 → all outputs 0. Release reset, hold inputs steady 20 cycles → no pulses.
- **Clean press:** ch0 driven to 0 and held → level[0]=1 and pressed[0] pulse exactly 7 edges after first capture. Channels 1 and 2 undisturbed.
- **Bounce rejection:**
  - ch1 toggles 0/1 every 2 cycles for 30 cycles, then stays 1 → level[1] stays 0, no pulses.
  - A 4-cycle low glitch → no change.
  - A 5-cycle-stable low → press.
- **Long press:** ch2 held pressed 40 cycles → one pressed pulse, one held pulse 10 cycles after level rise, then a released pulse 7 edges after the raw release. Never a second held pulse.
- **Simultaneous events and mid-operation reset:**
  - Press ch0 and ch2 on the same edge → both pressed pulses in the same cycle.
  - Assert reset_n=0 mid-hold → all outputs 0 immediately.
  - After release with buttons still down → fresh pressed pulses after 7 edges.
- **Polarity and disable:** with ACTIVE_LOW=0 and HOLD_CYCLES=0, raw 1 gives level 1 after 7 edges, and held stays 0 for a 100-cycle press.
